flash_read_seq: RTL and testbench

Command sequencer placed directly upstream of the `spi_cmd` SPI engine. Given a start address and byte count, it first polls the flash status register until the write-in-progress (WIP) bit clears. It then issues one single-IO READ (0x03) transaction per byte through `spi_cmd`'s trigger/busy handshake. Each returned byte goes out on a valid/ready stream toward the LED frame-buffer loader.

---
 rtl/flash_pkg.sv | 42 ++++
 rtl/flash_read_seq_if.sv | 43 ++++
 rtl/spi_cmd_issuer.sv | 57 +++++
 rtl/flash_read_seq.sv | 158 +++++++++++++++
 tb/tb_flash_read_seq.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read sequencer.
// Opcodes, command width, FSM state encodings and command packing.
package flash_pkg;

  localparam int CMD_BITS = 2080;
  localparam int CNT_W    = 9;
  localparam int WIP_BIT  = 0;

  localparam logic [7:0] READ_OPC = 8'h03;
  localparam logic [7:0] RDSR_OPC = 8'h05;

  typedef enum logic [3:0] {
    IDLE,
    P_ISSUE,
    P_ACK,
    P_WAIT,
    R_ISSUE,
    R_ACK,
    R_WAIT,
    OUT,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_ACK,
    I_WAIT
  } iss_t;

  function automatic logic [CMD_BITS-1:0] pack_cmd(
    input logic [7:0]  op,
    input logic [23:0] addr,
    input logic        rd
  );
    logic [CMD_BITS-1:0] p;
    p = '0;
    if (rd) p[31:0] = {op, addr};
    else    p[7:0]  = op;
    return p;
  endfunction

endpackage

// File: rtl/flash_read_seq_if.sv
// spi_cmd bus plus outgoing byte stream of the flash sequencer.
// master = sequencer side, slave = engine/consumer side.
interface flash_read_seq_if;
  import flash_pkg::*;

  logic                cmd_trigger;
  logic                cmd_busy;
  logic [CNT_W-1:0]    cmd_data_in_count;
  logic                cmd_data_out_count;
  logic [CMD_BITS-1:0] cmd_data_in;
  logic [7:0]          cmd_data_out;
  logic                cmd_quad;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output cmd_trigger,
    output cmd_data_in_count,
    output cmd_data_out_count,
    output cmd_data_in,
    output cmd_quad,
    output out_data,
    output out_valid,
    input  cmd_busy,
    input  cmd_data_out,
    input  out_ready
  );

  modport slave (
    input  cmd_trigger,
    input  cmd_data_in_count,
    input  cmd_data_out_count,
    input  cmd_data_in,
    input  cmd_quad,
    input  out_data,
    input  out_valid,
    output cmd_busy,
    output cmd_data_out,
    output out_ready
  );

endinterface

// File: rtl/spi_cmd_issuer.sv
// One spi_cmd transaction: trigger when idle, wait busy rise, wait fall.
// Payload/count pass straight through; the parent holds them stable.
module spi_cmd_issuer
  import flash_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [CNT_W-1:0]    count,
  input  logic [CMD_BITS-1:0] payload,
  output logic                finished,
  output logic [7:0]          rx_byte,
  output logic                cmd_trigger,
  input  logic                cmd_busy,
  output logic [CNT_W-1:0]    cmd_data_in_count,
  output logic [CMD_BITS-1:0] cmd_data_in,
  input  logic [7:0]          cmd_data_out
);

  iss_t st_q, st_d;

  // issue phase register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= I_IDLE;
    else        st_q <= st_d;
  end

  // trigger / ack / completion sequencing
  always_comb begin
    st_d        = st_q;
    cmd_trigger = 1'b0;
    finished    = 1'b0;
    unique case (st_q)
      I_IDLE: begin
        if (go && !cmd_busy) begin
          cmd_trigger = 1'b1;
          st_d        = I_ACK;
        end
      end
      I_ACK: begin
        if (cmd_busy) st_d = I_WAIT;
      end
      I_WAIT: begin
        if (!cmd_busy) begin
          finished = 1'b1;
          st_d     = I_IDLE;
        end
      end
      default: st_d = I_IDLE;
    endcase
  end

  assign rx_byte           = cmd_data_out;
  assign cmd_data_in       = payload;
  assign cmd_data_in_count = count;

endmodule

// File: rtl/flash_read_seq.sv
// Polls flash status until WIP clears, then reads bytes one at a time
// and streams each over valid/ready. One byte outstanding at most.
module flash_read_seq
  import flash_pkg::*;
#(
  parameter logic [7:0] READ_OP  = READ_OPC,
  parameter logic [7:0] RDSR_OP  = RDSR_OPC,
  parameter int         POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        error,
  flash_read_seq_if.master bus
);

  localparam int PW = $clog2(POLL_MAX + 1);

  state_t              state_q, state_d;
  logic [23:0]         addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic [PW-1:0]       poll_q, poll_d;
  logic [7:0]          data_q, data_d;
  logic                err_q, err_d;
  logic                is_p, is_r, go;
  logic                finished;
  logic [7:0]          rx_byte;
  logic [CNT_W-1:0]    cnt;
  logic [CMD_BITS-1:0] payload;

  assign is_p = (state_q == P_ISSUE) || (state_q == P_ACK) ||
                (state_q == P_WAIT);
  assign is_r = (state_q == R_ISSUE) || (state_q == R_ACK) ||
                (state_q == R_WAIT);
  assign go   = (state_q == P_ISSUE) || (state_q == R_ISSUE);

  // command selection follows the current phase
  always_comb begin
    cnt     = '0;
    payload = '0;
    unique case (1'b1)
      is_p: begin
        cnt     = CNT_W'(1);
        payload = pack_cmd(RDSR_OP, addr_q, 1'b0);
      end
      is_r: begin
        cnt     = CNT_W'(4);
        payload = pack_cmd(READ_OP, addr_q, 1'b1);
      end
      default: ;
    endcase
  end

  spi_cmd_issuer u_iss (
    .clk               (clk),
    .reset             (reset),
    .go                (go),
    .count             (cnt),
    .payload           (payload),
    .finished          (finished),
    .rx_byte           (rx_byte),
    .cmd_trigger       (bus.cmd_trigger),
    .cmd_busy          (bus.cmd_busy),
    .cmd_data_in_count (bus.cmd_data_in_count),
    .cmd_data_in       (bus.cmd_data_in),
    .cmd_data_out      (bus.cmd_data_out)
  );

  // sequencer state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      poll_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      poll_q  <= poll_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // next-state: poll loop, read loop, output handshake
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    poll_d  = poll_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (length == 16'd0) begin
            state_d = FIN;
          end else begin
            addr_d  = start_addr;
            rem_d   = length;
            poll_d  = '0;
            state_d = P_ISSUE;
          end
        end
      end
      P_ISSUE: if (bus.cmd_trigger) state_d = P_ACK;
      P_ACK:   if (bus.cmd_busy)    state_d = P_WAIT;
      P_WAIT: begin
        if (finished) begin
          if (!rx_byte[WIP_BIT]) begin
            state_d = R_ISSUE;
          end else if (poll_q + PW'(1) == PW'(POLL_MAX)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            poll_d  = poll_q + PW'(1);
            state_d = P_ISSUE;
          end
        end
      end
      R_ISSUE: if (bus.cmd_trigger) state_d = R_ACK;
      R_ACK:   if (bus.cmd_busy)    state_d = R_WAIT;
      R_WAIT: begin
        if (finished) begin
          data_d  = rx_byte;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          addr_d  = addr_q + 24'd1;
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? FIN : R_ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN) && !err_q;
  assign error = (state_q == FIN) && err_q;

  assign bus.out_valid          = (state_q == OUT);
  assign bus.out_data           = data_q;
  assign bus.cmd_data_out_count = 1'b1;
  assign bus.cmd_quad           = 1'b0;

endmodule

// File: tb/tb_flash_read_seq.sv
// Randomized bench: behavioural spi_cmd engine, stream consumer and
// a transaction-level expectation model of poll/read traffic.
module tb_flash_read_seq;
  import flash_pkg::*;

  localparam int PMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, error;

  flash_read_seq_if bus();

  flash_read_seq #(.POLL_MAX(PMAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  logic [7:0]  st_arr[$];
  logic [7:0]  rd_arr[$];
  int          st_idx = 0;
  int          rd_idx = 0;
  int          log_cnt[$];
  logic [31:0] log_pay[$];
  int          log_hi = 0;
  logic [7:0]  got_q[$];
  int          done_n = 0, err_n = 0, ov_cycles = 0;
  int          v_trig = 0, v_stab = 0, v_ovtrig = 0, v_both = 0;
  int          rmode = 0;

  // behavioural spi_cmd engine
  initial begin : spi_model
    int m;
    int cnt;
    logic [7:0] resp;
    m = 0; cnt = 0; resp = '0;
    bus.cmd_busy = 1'b0;
    bus.cmd_data_out = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m = 0;
        bus.cmd_busy = 1'b0;
        bus.cmd_data_out = '0;
      end else begin
        case (m)
          0: if (bus.cmd_trigger) begin
            log_cnt.push_back(int'(bus.cmd_data_in_count));
            log_pay.push_back(bus.cmd_data_in[31:0]);
            if (|bus.cmd_data_in[CMD_BITS-1:32]) log_hi++;
            if (bus.cmd_data_in_count == 9'd1) begin
              if (st_idx < st_arr.size()) begin
                resp = st_arr[st_idx]; st_idx++;
              end else resp = 8'h00;
            end else begin
              if (rd_idx < rd_arr.size()) begin
                resp = rd_arr[rd_idx]; rd_idx++;
              end else resp = 8'hEE;
            end
            cnt = int'($urandom_range(2, 0));
            m = 1;
          end
          1: if (cnt == 0) begin
            bus.cmd_busy = 1'b1;
            bus.cmd_data_out = 8'($urandom);
            cnt = int'($urandom_range(3, 0));
            m = 2;
          end else cnt--;
          default: if (cnt == 0) begin
            bus.cmd_busy = 1'b0;
            bus.cmd_data_out = resp;
            m = 0;
          end else cnt--;
        endcase
      end
    end
  end

  // stream consumer and protocol monitor
  initial begin : mon
    logic prev_trig, pv;
    logic [7:0] pd;
    int vc;
    prev_trig = 1'b0; pv = 1'b0; pd = '0; vc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.out_valid) vc = 0;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(1, 0));
        default: bus.out_ready = (got_q.size() != 0) || (vc >= 10);
      endcase
      if (bus.out_valid) begin vc++; ov_cycles++; end
      if (pv && bus.out_valid && bus.out_data !== pd) v_stab++;
      if (bus.out_valid && bus.cmd_trigger) v_ovtrig++;
      if (prev_trig && bus.cmd_trigger) v_trig++;
      if (done) done_n++;
      if (error) err_n++;
      if (done && error) v_both++;
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      pv = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      prev_trig = bus.cmd_trigger;
    end
  end

  task automatic fill_rd(input int n);
    rd_arr.delete();
    for (int i = 0; i < n; i++) rd_arr.push_back(8'($urandom));
  endtask

  task automatic run(input string nm, input logic [23:0] a,
                     input int len, input int rm);
    int pol, nrd, d0, e0, cyc;
    bit ee;
    logic [7:0] s;
    logic [23:0] ea;
    pol = PMAX; ee = 1'b1;
    for (int i = 0; i < PMAX; i++) begin
      s = (i < st_arr.size()) ? st_arr[i] : 8'h00;
      if (!s[0]) begin pol = i + 1; ee = 1'b0; break; end
    end
    nrd = ee ? 0 : len;
    log_cnt.delete(); log_pay.delete(); got_q.delete();
    st_idx = 0; rd_idx = 0; ov_cycles = 0; rmode = rm; log_hi = 0;
    d0 = done_n; e0 = err_n;
    @(negedge clk);
    start = 1'b1; start_addr = a; length = 16'(len);
    @(negedge clk);
    start = 1'b0; start_addr = 24'($urandom); length = 16'($urandom);
    cyc = 0;
    while (done_n == d0 && err_n == e0 && cyc < 4000) begin
      @(negedge clk); cyc++;
    end
    check({nm, ":finish"}, 64'(cyc < 4000), 1);
    @(negedge clk);
    check({nm, ":done"}, 64'(done_n - d0), 64'(!ee));
    check({nm, ":error"}, 64'(err_n - e0), 64'(ee));
    check({nm, ":busy_end"}, 64'(busy), 0);
    check({nm, ":ntxn"}, 64'(log_cnt.size()), 64'(pol + nrd));
    check({nm, ":hibits"}, 64'(log_hi), 0);
    for (int i = 0; i < log_cnt.size(); i++) begin
      if (i < pol) begin
        check({nm, ":rdsr_cnt"}, 64'(log_cnt[i]), 1);
        check({nm, ":rdsr_pay"}, 64'(log_pay[i]), 64'h05);
      end else begin
        ea = a + 24'(i - pol);
        check({nm, ":read_cnt"}, 64'(log_cnt[i]), 4);
        check({nm, ":read_pay"}, 64'(log_pay[i]), 64'({8'h03, ea}));
      end
    end
    check({nm, ":nbytes"}, 64'(got_q.size()), 64'(nrd));
    for (int i = 0; i < got_q.size() && i < nrd; i++)
      check({nm, ":byte"}, 64'(got_q[i]), 64'(rd_arr[i]));
    if (ee) check({nm, ":no_valid"}, 64'(ov_cycles), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin : main
    int d0, e0, cyc, k, len;
    logic [23:0] a;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_valid", 64'(bus.out_valid), 0);
    check("rst_data", 64'(bus.out_data), 0);
    check("rst_trig", 64'(bus.cmd_trigger), 0);
    check("rst_din", 64'(|bus.cmd_data_in), 0);
    check("rst_dcnt", 64'(bus.cmd_data_in_count), 0);
    check("rst_ocnt", 64'(bus.cmd_data_out_count), 1);
    check("rst_quad", 64'(bus.cmd_quad), 0);
    reset = 1'b1;
    @(negedge clk);

    st_arr = {8'h00};
    rd_arr = {8'hA1, 8'hB2, 8'hC3};
    run("basic", 24'h000100, 3, 0);

    st_arr = {8'h01, 8'h01, 8'h00};
    fill_rd(2);
    run("poll3", 24'($urandom), 2, 1);

    st_arr = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    rd_arr.delete();
    run("plimit", 24'h123456, 3, 0);

    st_arr = {8'h00};
    fill_rd(2);
    run("wrap", 24'hFFFFFF, 2, 1);

    st_arr = {8'h02};
    fill_rd(3);
    run("stall", 24'h00ABCD, 3, 2);
    check("stall_cycles", 64'(ov_cycles >= 13), 1);

    log_cnt.delete();
    d0 = done_n;
    @(negedge clk);
    start = 1'b1; length = 16'd0; start_addr = 24'h000777;
    @(negedge clk);
    check("len0_busy", 64'(busy), 1);
    check("len0_done", 64'(done), 1);
    check("len0_error", 64'(error), 0);
    start = 1'b0;
    @(negedge clk);
    check("len0_after", 64'({busy, done}), 0);
    repeat (5) @(negedge clk);
    check("len0_trig", 64'(log_cnt.size()), 0);
    check("len0_ndone", 64'(done_n - d0), 1);

    log_cnt.delete(); log_pay.delete();
    st_arr = {8'h00}; rd_arr = {8'h11, 8'h22};
    st_idx = 0; rd_idx = 0; rmode = 0;
    d0 = done_n; e0 = err_n;
    @(negedge clk);
    start = 1'b1; start_addr = 24'h000040; length = 16'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(log_cnt.size() >= 2 && bus.cmd_busy) && cyc < 500) begin
      @(posedge clk); cyc++;
    end
    check("rwait_reach", 64'(cyc < 500), 1);
    #2 reset = 1'b0;
    @(negedge clk);
    check("mid_busy", 64'(busy), 0);
    check("mid_valid", 64'(bus.out_valid), 0);
    check("mid_data", 64'(bus.out_data), 0);
    check("mid_trig", 64'(bus.cmd_trigger), 0);
    check("mid_din", 64'(|bus.cmd_data_in), 0);
    check("mid_dcnt", 64'(bus.cmd_data_in_count), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_nopulse", 64'((done_n - d0) + (err_n - e0)), 0);
    st_arr = {8'h01, 8'h00};
    fill_rd(2);
    run("post_rst", 24'h000040, 2, 0);

    for (int t = 0; t < 6; t++) begin
      st_arr.delete();
      k = int'($urandom_range(5, 0));
      for (int i = 0; i < k; i++) st_arr.push_back(8'($urandom) | 8'h01);
      st_arr.push_back(8'($urandom) & 8'hFE);
      len = int'($urandom_range(5, 1));
      a = ($urandom_range(1, 0) == 1) ? 24'hFFFFFF - 24'($urandom_range(3, 0))
                                       : 24'($urandom);
      fill_rd(len);
      run("rand", a, len, int'($urandom_range(1, 0)));
    end

    check("trig_gap", 64'(v_trig), 0);
    check("out_stable", 64'(v_stab), 0);
    check("no_trig_in_out", 64'(v_ovtrig), 0);
    check("done_err_excl", 64'(v_both), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
